uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
Downstream stage of the 32-bit receive FIFO (fifo_42). It pops one 32-bit word at a time and serialises it LSB-byte-first into four uart_send transfers using the uart_en / uart_tx_busy handshake. It replaces uart_loop as the driver of uart_send when words, not raw bytes, are echoed or forwarded.

Parameters:
DATA_WIDTH, 32, FIFO word width; must be a multiple of 8; NBYTES = DATA_WIDTH/8
CNT_WIDTH, 6, width of the FIFO data_count input
BUSY_TIMEOUT, 16, cycles to wait for uart_tx_busy to rise after a uart_en pulse before the byte is treated as accepted

Ports:
sys_clk  in  1  system clock, all logic on its rising edge
sys_rst_n  in  1  asynchronous active-low reset
fifo_count  in  CNT_WIDTH  FIFO occupancy; a word is available when nonzero
fifo_dout  in  DATA_WIDTH  FIFO read data, valid exactly 1 cycle after rd_en
rd_en  out  1  FIFO pop strobe, single-cycle pulse
uart_tx_busy  in  1  uart_send busy flag
uart_en  out  1  uart_send start strobe, single-cycle pulse
uart_din  out  8  byte to send, stable from the uart_en cycle until the byte completes
tx_active  out  1  high whenever the FSM is not IDLE
words_sent  out  16  count of fully transmitted words, wraps 0xFFFF->0

Behaviour:
- Reset (async, active low, any state): FSM returns to IDLE; rd_en=0, uart_en=0, uart_din=0, tx_active=0, words_sent=0, byte index=0, word register=0. A partially sent word is discarded. No pulse is emitted in the cycle reset deasserts.
- States:
  - IDLE: if fifo_count!=0 and uart_tx_busy=0, go to POP. Otherwise stay.
  - POP: rd_en=1 for this cycle only. Next state is LATCH.
  - LATCH: capture fifo_dout into the word register, set byte index=0, go to LOAD.
  - LOAD: uart_din <= word[8*idx+7 : 8*idx]. Go to STROBE.
  - STROBE: uart_en=1 for one cycle, clear the timeout counter, go to WAIT_HI.
  - WAIT_HI: if uart_tx_busy=1, go to WAIT_LO. Else increment the timeout counter; when it reaches BUSY_TIMEOUT-1, go to WAIT_LO anyway.
  - WAIT_LO: when uart_tx_busy=0, go to NEXT.
  - NEXT: if idx==NBYTES-1, increment words_sent and go to IDLE. Otherwise increment idx and go to LOAD.
- Latency:
  - fifo_count 0->nonzero with busy low: rd_en is asserted on the next clock.
  - First uart_en follows 3 cycles after rd_en.
- Ordering and pulsing:
  - Bytes are sent in order byte0 = bits[7:0] through byte(NBYTES-1).
  - Exactly NBYTES uart_en pulses and one rd_en pulse per word.
  - uart_en is never asserted while uart_tx_busy=1.
- Empty FIFO: no rd_en is issued when fifo_count==0, including in the cycle immediately after a word completes.
- Back-to-back words: IDLE is entered for at least 1 cycle between words. A FIFO refill during transmission does not disturb the current word.
- fifo_count changes while in POP/LATCH are ignored; the FIFO guarantees data for the pop issued.
- uart_tx_busy stuck high: the FSM stalls in WAIT_LO indefinitely. This is not an error; reset recovers.
- tx_active is a registered decode of state != IDLE.

Optional Feature:
UART_WORD_TX_CHECKSUM_EN
- Defined: after byte NBYTES-1, one extra byte is sent through the same LOAD/STROBE/WAIT path. Its value is the XOR of all NBYTES data bytes, giving NBYTES+1 uart_en pulses per word. words_sent increments only after the checksum byte completes.
- Undefined: no checksum byte, and no checksum register is present in the netlist.

Test Plan:
1. Reset with fifo_count=0 for 100 cycles -> rd_en and uart_en never assert; words_sent=0; tx_active=0.
2. fifo_count=1, fifo_dout=0xA1B2C3D4 one cycle after rd_en, bus model holds busy for 20 cycles per byte -> one rd_en, then uart_din sequence D4, C3, B2, A1 with 4 uart_en pulses; words_sent=1; returns to IDLE.
3. fifo_count=3 with words 0x00000001, 0xFFFFFFFF, 0x12345678 -> 12 bytes in order 01 00 00 00 FF FF FF FF 78 56 34 12; exactly 3 rd_en pulses; words_sent=3.
4. Bus model never raises busy -> each byte advances after BUSY_TIMEOUT=16 cycles; word completes; words_sent increments.
5. Assert sys_rst_n=0 during byte 2 of 0xDEADBEEF, release, then supply 0x11223344 -> outputs reset immediately; the next transmission is 44 33 22 11 with no DE/AD bytes; words_sent=1.
6. With UART_WORD_TX_CHECKSUM_EN defined, word 0x01020304 -> bytes 04 03 02 01 04 (XOR=0x04); 5 uart_en pulses; words_sent=1.

Source files
------------

// File: rtl/uart_word_tx.sv
// Pops 32-bit words from the receive FIFO and sends each one LSB byte first through uart_send.
// Optional checksum byte: define UART_WORD_TX_CHECKSUM_EN.
module uart_word_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = 6,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [CNT_WIDTH-1:0]  fifo_count,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  rd_en,
  input  logic                  uart_tx_busy,
  output logic                  uart_en,
  output logic [7:0]            uart_din,
  output logic                  tx_active,
  output logic [15:0]           words_sent
);

  localparam int NBYTES = DATA_WIDTH / 8;
`ifdef UART_WORD_TX_CHECKSUM_EN
  localparam int NSLOTS = NBYTES + 1;
`else
  localparam int NSLOTS = NBYTES;
`endif
  localparam int IDX_W = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int TMO_W = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLOTS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, POP, LATCH, LOAD, STROBE, WAIT_HI, WAIT_LO, NEXT
  } state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   word_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [TMO_W-1:0]        tmo_reg;
  logic [7:0]              byte_sel;

  // Byte mux; the slot past the last data byte carries the XOR checksum when enabled.
  always_comb begin
`ifdef UART_WORD_TX_CHECKSUM_EN
    logic [7:0] csum;
    csum = '0;
    for (int i = 0; i < NBYTES; i++) csum = csum ^ word_reg[8*i +: 8];
    byte_sel = csum;
`else
    byte_sel = '0;
`endif
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_reg == IDX_W'(i)) byte_sel = word_reg[8*i +: 8];
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    uart_en    = 1'b0;
    case (state_reg)
      IDLE:    if (fifo_count != '0 && !uart_tx_busy) state_next = POP;
      POP: begin
        rd_en      = 1'b1;
        state_next = LATCH;
      end
      LATCH:   state_next = LOAD;
      LOAD:    state_next = STROBE;
      STROBE: begin
        uart_en    = 1'b1;
        state_next = WAIT_HI;
      end
      // A sender that never raises busy must not hang the word forever.
      WAIT_HI: if (uart_tx_busy || tmo_reg == TMO_LAST) state_next = WAIT_LO;
      WAIT_LO: if (!uart_tx_busy) state_next = NEXT;
      NEXT:    state_next = (idx_reg == LAST_IDX) ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg  <= IDLE;
      tx_active  <= 1'b0;
      word_reg   <= '0;
      idx_reg    <= '0;
      tmo_reg    <= '0;
      uart_din   <= '0;
      words_sent <= '0;
    end else begin
      state_reg <= state_next;
      tx_active <= (state_next != IDLE);
      case (state_reg)
        LATCH: begin
          word_reg <= fifo_dout;
          idx_reg  <= '0;
        end
        LOAD:    uart_din <= byte_sel;
        STROBE:  tmo_reg <= '0;
        WAIT_HI: if (!uart_tx_busy && tmo_reg != TMO_LAST) tmo_reg <= tmo_reg + 1'b1;
        NEXT: begin
          if (idx_reg == LAST_IDX) words_sent <= words_sent + 16'd1;
          else                     idx_reg    <= idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with a FIFO model and a uart_send busy model.
// Expects the extra checksum byte when UART_WORD_TX_CHECKSUM_EN is defined.
module tb_uart_word_tx;

  localparam int BUSY_TIMEOUT = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [5:0]  fifo_count = '0;
  logic [31:0] fifo_dout = '0;
  logic        rd_en;
  logic        uart_tx_busy = 1'b0;
  logic        uart_en;
  logic [7:0]  uart_din;
  logic        tx_active;
  logic [15:0] words_sent;

  int tests = 0, fails = 0;
  int cyc = 0, hold = 20, busy_cnt = 0;
  int rd_pulses = 0, en_pulses = 0, first_rd = -1, first_en = -1, last_en = -1;
  int min_gap = 100000, max_gap = 0, push_cyc = 0;
  logic [31:0] fifo_q[$];
  logic [7:0]  sent_q[$];
  logic [7:0]  exp_q[$];

  uart_word_tx #(.DATA_WIDTH(32), .CNT_WIDTH(6), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .fifo_count(fifo_count),
    .fifo_dout(fifo_dout), .rd_en(rd_en), .uart_tx_busy(uart_tx_busy),
    .uart_en(uart_en), .uart_din(uart_din), .tx_active(tx_active),
    .words_sent(words_sent)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample DUT outputs on the falling edge, then update the FIFO and bus models.
  task automatic tick();
    @(negedge sys_clk);
    cyc++;
    if (uart_en) begin
      check("en_while_busy", 32'(uart_tx_busy), 32'd0);
      en_pulses++;
      sent_q.push_back(uart_din);
      $display("[TB] cycle %0d byte %02h", cyc, uart_din);
      if (first_en < 0) first_en = cyc;
      if (last_en >= 0) begin
        if (cyc - last_en < min_gap) min_gap = cyc - last_en;
        if (cyc - last_en > max_gap) max_gap = cyc - last_en;
      end
      last_en = cyc;
    end
    if (rd_en) begin
      rd_pulses++;
      if (first_rd < 0) first_rd = cyc;
      if (fifo_q.size() == 0) check("rd_on_empty", 32'd1, 32'd0);
      else fifo_dout = fifo_q.pop_front();
    end
    fifo_count = 6'(fifo_q.size());
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) uart_tx_busy = 1'b0;
    end
    if (uart_en && hold > 0) begin
      uart_tx_busy = 1'b1;
      busy_cnt = hold;
    end
  endtask

  task automatic clear_stats();
    rd_pulses = 0; en_pulses = 0; first_rd = -1; first_en = -1; last_en = -1;
    min_gap = 100000; max_gap = 0;
    sent_q.delete(); exp_q.delete();
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_count = 6'(fifo_q.size());
    push_cyc = cyc;
  endtask

  task automatic exp_word(input logic [7:0] b0, b1, b2, b3, ck);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3);
`ifdef UART_WORD_TX_CHECKSUM_EN
    exp_q.push_back(ck);
`else
    if (ck === 8'hxx) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic wait_words(input int target, input string tag);
    for (int i = 0; i < 5000 && words_sent != 16'(target); i++) tick();
    check(tag, 32'(words_sent), 32'(target));
    repeat (3) tick();
    check({tag, "_idle"}, 32'(tx_active), 32'd0);
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_nbytes"}, 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < sent_q.size()) check($sformatf("%s_b%0d", tag, i), 32'(sent_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    // 1: idle under reset and with an empty FIFO
    repeat (3) tick();
    check("t1_rst_rd", 32'(rd_en), 32'd0);
    check("t1_rst_en", 32'(uart_en), 32'd0);
    check("t1_rst_din", 32'(uart_din), 32'd0);
    sys_rst_n = 1'b1;
    repeat (100) tick();
    check("t1_rd_pulses", 32'(rd_pulses), 32'd0);
    check("t1_en_pulses", 32'(en_pulses), 32'd0);
    check("t1_words", 32'(words_sent), 32'd0);
    check("t1_active", 32'(tx_active), 32'd0);

    // 2: single word, busy held 20 cycles per byte
    clear_stats();
    hold = 20;
    push(32'hA1B2C3D4);
    exp_word(8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h04);
    wait_words(1, "t2_words");
    check("t2_rd_pulses", 32'(rd_pulses), 32'd1);
    check("t2_rd_latency", 32'(first_rd - push_cyc), 32'd1);
    check("t2_en_latency", 32'(first_en - first_rd), 32'd3);
    check_bytes("t2");

    // 3: three queued words back to back
    clear_stats();
    push(32'h00000001); push(32'hFFFFFFFF); push(32'h12345678);
    exp_word(8'h01, 8'h00, 8'h00, 8'h00, 8'h01);
    exp_word(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
    exp_word(8'h78, 8'h56, 8'h34, 8'h12, 8'h08);
    wait_words(4, "t3_words");
    check("t3_rd_pulses", 32'(rd_pulses), 32'd3);
    check_bytes("t3");

    // 4: busy never rises, each byte advances on the timeout
    clear_stats();
    hold = 0;
    push(32'h5A5AA5A5);
    exp_word(8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h00);
    wait_words(5, "t4_words");
    check("t4_gap_min", 32'(min_gap >= BUSY_TIMEOUT), 32'd1);
    check("t4_gap_max", 32'(max_gap <= BUSY_TIMEOUT + 8), 32'd1);
    check_bytes("t4");

    // 5: reset in the middle of a word, then a fresh word
    clear_stats();
    hold = 20;
    push(32'hDEADBEEF);
    for (int i = 0; i < 3000 && en_pulses < 3; i++) tick();
    check("t5_reach_byte2", 32'(en_pulses >= 3), 32'd1);
    repeat (5) tick();
    sys_rst_n = 1'b0;
    #1;
    check("t5_rst_active", 32'(tx_active), 32'd0);
    check("t5_rst_words", 32'(words_sent), 32'd0);
    check("t5_rst_din", 32'(uart_din), 32'd0);
    uart_tx_busy = 1'b0; busy_cnt = 0;
    fifo_q.delete(); fifo_count = '0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    clear_stats();
    repeat (2) tick();
    push(32'h11223344);
    exp_word(8'h44, 8'h33, 8'h22, 8'h11, 8'h44);
    wait_words(1, "t5_words");
    check("t5_rd_pulses", 32'(rd_pulses), 32'd1);
    check_bytes("t5");

`ifdef UART_WORD_TX_CHECKSUM_EN
    // 6: checksum byte appended
    clear_stats();
    push(32'h01020304);
    exp_word(8'h04, 8'h03, 8'h02, 8'h01, 8'h04);
    wait_words(2, "t6_words");
    check("t6_en_pulses", 32'(en_pulses), 32'd5);
    check_bytes("t6");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
